// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the single-clock FIFO.
//   DEPTH()   - number of words for a given address width (1 << addr_len).
//   ptr_t     - read/write pointer type for the default geometry
//               (ADDR_LEN = 4): ADDR_LEN index bits plus one wrap bit.
//   rd_mode_e - read-port flavour: registered (RD_STD) or
//               first-word-fall-through (RD_FWFT).
package fifo_pkg;

  localparam int DEFAULT_ADDR_LEN = 4;

  function automatic int DEPTH(input int addr_len);
    return 1 << addr_len;
  endfunction

  typedef logic [DEFAULT_ADDR_LEN:0] ptr_t;

  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port RAM, synchronous write / asynchronous read.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - combinational read data (mem[raddr])
// Contents are not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_LEN-1:0] waddr,
  input  logic [DATA_LEN-1:0] wdata,
  input  logic [ADDR_LEN-1:0] raddr,
  output logic [DATA_LEN-1:0] rdata
);

  localparam int MEM_DEPTH = DEPTH(ADDR_LEN);

  logic [DATA_LEN-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with selectable read mode,
// occupancy count, almost-full/almost-empty flags and sticky error flags.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   write_en, wdata_i   - write request and data
//   read_en             - read request (FWFT: pop of the head word)
//   clr_err_i           - clears the sticky overflow/underflow flags
//   rdata_o, rvalid_o   - read data and its valid indication
//   wfull_o, rempty_o   - count == depth / count == 0
//   almost_full_o       - count >= AF_LEVEL
//   almost_empty_o      - count <= AE_LEVEL
//   count_o             - occupancy 0..depth
//   overflow_o          - sticky: write attempted while it could not be accepted
//   underflow_o         - sticky: read attempted while empty
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 4,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                write_en,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic                read_en,
  input  logic                clr_err_i,
  output logic [DATA_LEN-1:0] rdata_o,
  output logic                rvalid_o,
  output logic                wfull_o,
  output logic                rempty_o,
  output logic                almost_full_o,
  output logic                almost_empty_o,
  output logic [ADDR_LEN:0]   count_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  localparam int             DEPTH_N   = DEPTH(ADDR_LEN);
  localparam logic [ADDR_LEN:0] DEPTH_CNT = DEPTH_N[ADDR_LEN:0];
  localparam logic [ADDR_LEN:0] AF_CNT    = AF_LEVEL[ADDR_LEN:0];
  localparam logic [ADDR_LEN:0] AE_CNT    = AE_LEVEL[ADDR_LEN:0];
  localparam rd_mode_e       RD_MODE   = (FWFT != 0) ? RD_FWFT : RD_STD;

  // Pointers carry one extra wrap bit; only the low ADDR_LEN bits address memory.
  logic [ADDR_LEN:0]   wptr;
  logic [ADDR_LEN:0]   rptr;
  logic [ADDR_LEN:0]   count;
  logic [ADDR_LEN:0]   count_next;
  logic                wr_acc;
  logic                rd_acc;
  logic [DATA_LEN-1:0] mem_rdata;

  // A write into a full FIFO is still taken when a read frees a slot in the
  // same cycle; a read on an empty FIFO is never taken, even with a write.
  assign rd_acc = read_en & ~rempty_o;
  assign wr_acc = write_en & (~wfull_o | rd_acc);

  assign count_next = count + {{ADDR_LEN{1'b0}}, wr_acc} - {{ADDR_LEN{1'b0}}, rd_acc};

  fifo_mem #(
    .DATA_LEN (DATA_LEN),
    .ADDR_LEN (ADDR_LEN)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[ADDR_LEN-1:0]),
    .wdata (wdata_i),
    .raddr (rptr[ADDR_LEN-1:0]),
    .rdata (mem_rdata)
  );

  // Pointers, occupancy and status flags. Flags are registered from
  // count_next so they line up with count_o after each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      wfull_o        <= 1'b0;
      rempty_o       <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rptr <= rptr + 1'b1;
      end
      count          <= count_next;
      wfull_o        <= (count_next == DEPTH_CNT);
      rempty_o       <= (count_next == '0);
      almost_full_o  <= (count_next >= AF_CNT);
      almost_empty_o <= (count_next <= AE_CNT);
    end
  end

  assign count_o = count;

  // Sticky error flags; a new error in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (write_en & ~wr_acc) begin
        overflow_o <= 1'b1;
      end else if (clr_err_i) begin
        overflow_o <= 1'b0;
      end
      if (read_en & rempty_o) begin
        underflow_o <= 1'b1;
      end else if (clr_err_i) begin
        underflow_o <= 1'b0;
      end
    end
  end

  generate
    if (RD_MODE == RD_FWFT) begin : g_fwft
      // Head word is presented combinationally; forced to zero while empty so
      // the output is clean after reset and never shows stale memory.
      assign rdata_o  = rempty_o ? '0 : mem_rdata;
      assign rvalid_o = ~rempty_o;
    end else begin : g_std
      logic [DATA_LEN-1:0] rdata_reg;
      logic                rvalid_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_reg  <= '0;
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= rd_acc;
          if (rd_acc) begin
            rdata_reg <= mem_rdata;
          end
        end
      end

      assign rdata_o  = rdata_reg;
      assign rvalid_o = rvalid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance
  logic        s_we, s_re, s_clr;
  logic [31:0] s_wd, s_rd;
  logic        s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_uvf;
  logic [4:0]  s_cnt;

  // FWFT instance
  logic        f_we, f_re, f_clr;
  logic [31:0] f_wd, f_rd;
  logic        f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_uvf;
  logic [4:0]  f_cnt;

  sync_fifo_param #(.DATA_LEN(32), .ADDR_LEN(4), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(2)) u_std (
    .clk(clk), .rst_n(rst_n), .write_en(s_we), .wdata_i(s_wd), .read_en(s_re),
    .clr_err_i(s_clr), .rdata_o(s_rd), .rvalid_o(s_rv), .wfull_o(s_full),
    .rempty_o(s_empty), .almost_full_o(s_af), .almost_empty_o(s_ae),
    .count_o(s_cnt), .overflow_o(s_ovf), .underflow_o(s_uvf)
  );

  sync_fifo_param #(.DATA_LEN(32), .ADDR_LEN(4), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(2)) u_fwft (
    .clk(clk), .rst_n(rst_n), .write_en(f_we), .wdata_i(f_wd), .read_en(f_re),
    .clr_err_i(f_clr), .rdata_o(f_rd), .rvalid_o(f_rv), .wfull_o(f_full),
    .rempty_o(f_empty), .almost_full_o(f_af), .almost_empty_o(f_ae),
    .count_o(f_cnt), .overflow_o(f_ovf), .underflow_o(f_uvf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the standard instance
  logic [31:0] q[$];
  logic [31:0] m_rdata;
  logic        m_rvalid, m_ovf, m_uvf;
  int          wr_count;
  int          wraps;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_std_state();
    check("count", 32'(s_cnt), 32'(q.size()));
    check("rempty", 32'(s_empty), 32'(q.size() == 0));
    check("wfull", 32'(s_full), 32'(q.size() == 16));
    check("almost_full", 32'(s_af), 32'(q.size() >= 12));
    check("almost_empty", 32'(s_ae), 32'(q.size() <= 2));
    check("overflow", 32'(s_ovf), 32'(m_ovf));
    check("underflow", 32'(s_uvf), 32'(m_uvf));
    check("rvalid", 32'(s_rv), 32'(m_rvalid));
    check("rdata", s_rd, m_rdata);
  endtask

  // One clock of the standard instance: predict acceptance from the model,
  // drive, clock, update the model, compare.
  task automatic step(input logic we, input logic [31:0] wd, input logic re,
                      input logic clr, input bit verbose);
    bit rd_ok, wr_ok;
    rd_ok = re && (q.size() > 0);
    wr_ok = we && ((q.size() < 16) || rd_ok);
    s_we = we; s_wd = wd; s_re = re; s_clr = clr;
    @(posedge clk);
    #1;
    if (rd_ok) m_rdata = q.pop_front();
    m_rvalid = rd_ok;
    if (wr_ok) begin
      q.push_back(wd);
      wr_count++;
      if (wr_count % 16 == 0) wraps++;
    end
    if (we && !wr_ok) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (re && q.size() == 0 && !rd_ok && !wr_ok) m_uvf = 1'b1;
    else if (re && !rd_ok) m_uvf = 1'b1;
    else if (clr) m_uvf = 1'b0;
    if (verbose)
      $display("std we=%0d wd=%08h re=%0d clr=%0d -> cnt=%0d rv=%0d rd=%08h ovf=%0d uvf=%0d",
               we, wd, re, clr, s_cnt, s_rv, s_rd, s_ovf, s_uvf);
    check_std_state();
  endtask

  initial begin
    s_we = 0; s_wd = '0; s_re = 0; s_clr = 0;
    f_we = 0; f_wd = '0; f_re = 0; f_clr = 0;
    m_rdata = '0; m_rvalid = 0; m_ovf = 0; m_uvf = 0;
    wr_count = 0; wraps = 0;

    // Reset and idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_std_state();
    check("fwft_rst_rvalid", 32'(f_rv), 32'd0);
    check("fwft_rst_rdata", f_rd, 32'd0);
    check("fwft_rst_rempty", 32'(f_empty), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(0, 32'h0, 0, 0, 1);

    // Fill with 0x00..0x0F, then overflow, then clear
    for (int i = 0; i < 16; i++) step(1, 32'(i), 0, 0, 1);
    step(1, 32'h99, 0, 0, 1);
    step(0, 32'h0, 0, 1, 1);

    // Full with simultaneous read + write: count stays at depth
    for (int i = 0; i < 4; i++) step(1, 32'hAA, 1, 0, 1);

    // Drain: 0x04..0x0F then 0xAA x4 (scoreboard order)
    for (int i = 0; i < 16; i++) step(0, 32'h0, 1, 0, 1);
    step(0, 32'h0, 0, 0, 1);

    // Underflow on empty, clear, then write+read on empty
    step(0, 32'h0, 1, 0, 1);
    step(0, 32'h0, 0, 1, 1);
    step(1, 32'h55, 1, 0, 1);
    step(0, 32'h0, 1, 1, 1);
    step(0, 32'h0, 0, 0, 1);

    // Clear and new error in the same cycle: error wins
    step(0, 32'h0, 1, 1, 1);
    step(0, 32'h0, 0, 1, 1);

    // Random traffic with scoreboard
    for (int i = 0; i < 2000; i++) begin
      logic we, re, clr;
      we  = ($urandom_range(0, 99) < 85);
      re  = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 99) < 5);
      step(we, $urandom, re, clr, 0);
    end
    $display("random traffic done: writes=%0d wraps=%0d", wr_count, wraps);
    check("wrap_crossings_ge_50", 32'(wraps >= 50), 32'd1);

    // FWFT instance: write-to-visible latency of one cycle, pop to empty
    f_we = 1; f_wd = 32'h1234;
    @(posedge clk);
    #1;
    f_we = 0;
    $display("fwft write 0x1234 -> rv=%0d rd=%08h empty=%0d", f_rv, f_rd, f_empty);
    check("fwft_rdata", f_rd, 32'h1234);
    check("fwft_rvalid", 32'(f_rv), 32'd1);
    check("fwft_count", 32'(f_cnt), 32'd1);
    f_re = 1;
    @(posedge clk);
    #1;
    f_re = 0;
    $display("fwft pop -> rv=%0d empty=%0d cnt=%0d", f_rv, f_empty, f_cnt);
    check("fwft_rempty_after_pop", 32'(f_empty), 32'd1);
    check("fwft_rvalid_after_pop", 32'(f_rv), 32'd0);
    check("fwft_underflow", 32'(f_uvf), 32'd0);

    // Two words in FWFT: head advances on pop
    f_we = 1; f_wd = 32'hBEEF0001;
    @(posedge clk); #1;
    f_wd = 32'hBEEF0002;
    @(posedge clk); #1;
    f_we = 0;
    check("fwft_head0", f_rd, 32'hBEEF0001);
    f_re = 1;
    @(posedge clk); #1;
    f_re = 0;
    $display("fwft pop -> rd=%08h cnt=%0d", f_rd, f_cnt);
    check("fwft_head1", f_rd, 32'hBEEF0002);
    check("fwft_count_after_pop", 32'(f_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
